// File: rtl/mul_share_arbiter_pkg.sv
// mul_share_arbiter_pkg: state encodings and default widths for the shared multiplier arbiter
package mul_share_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, RESP = 2'd2} state_t;
  localparam int NREQ_D = 2;
  localparam int W_D = 16;
  localparam int TIMEOUT_D = 64;
endpackage

// File: rtl/mul_share_arbiter_rr_pick.sv
// mul_share_arbiter_rr_pick: first set request at or above ptr, searching upward with wrap
module mul_share_arbiter_rr_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic            any,
  output logic [1:0]      idx
);
  logic [3:0] r4;
  logic [1:0] j;
  assign r4 = 4'(req);
  assign any = |req;
  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    idx = '0;
    j = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = 2'((int'(ptr) + i) % NREQ);
      if (r4[j]) idx = j;
    end
  end
endmodule

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one multi-cycle multiplier among NREQ controllers,
// with a timeout that aborts a multiplier that never raises done.
module mul_share_arbiter
  import mul_share_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_D,
  parameter int W = W_D,
  parameter int TIMEOUT = TIMEOUT_D
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  output logic [NREQ-1:0]   ack,
  output logic [2*W-1:0]    result,
  output logic              err,
  output logic              busy,
  output logic [1:0]        grant_id,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  output logic              mul_reset,
  input  logic              mul_done,
  input  logic [2*W-1:0]    mul_p
);
  localparam int CW = $clog2(TIMEOUT);
  state_t state, state_nx;
  logic [1:0] ptr, idx;
  logic any, tmo;
  logic [CW-1:0] cnt;
  mul_share_arbiter_rr_pick #(.NREQ(NREQ)) u_pick (.req(req), .ptr(ptr), .any(any), .idx(idx));
  assign tmo = cnt == CW'(TIMEOUT - 1);
  assign busy = state != IDLE;
  assign mul_reset = state != RUN;
  always_comb begin
    state_nx = state == IDLE ? (any ? RUN : IDLE)
             : state == RUN  ? ((mul_done || tmo) ? RESP : RUN)
             : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      ack <= '0;
      err <= 1'b0;
      result <= '0;
      grant_id <= '0;
      mul_a <= '0;
      mul_b <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      ack <= '0;
      if (state == IDLE && any) begin
        grant_id <= idx;
        mul_a <= a_in[idx*W +: W];
        mul_b <= b_in[idx*W +: W];
        cnt <= '0;
      end
      // Done takes priority over a timeout landing in the same cycle.
      if (state == RUN) begin
        cnt <= cnt + 1'b1;
        if (mul_done || tmo) begin
          result <= mul_done ? mul_p : '0;
          err <= !mul_done;
          ack <= NREQ'(1) << grant_id;
        end
      end
      if (state == RESP) ptr <= grant_id == 2'(NREQ - 1) ? 2'd0 : grant_id + 2'd1;
    end
  end
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: directed scoreboard bench with a behavioural multiplier of programmable latency
module tb_mul_share_arbiter;
  localparam int NREQ = 2;
  localparam int W = 16;
  localparam int TO = 8;
  typedef struct packed {logic [1:0] idx; logic [31:0] res; logic err;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*W-1:0] a_in = '0;
  logic [NREQ*W-1:0] b_in = '0;
  logic [NREQ-1:0] ack;
  logic [2*W-1:0] result;
  logic err, busy, mul_reset, mul_done;
  logic [1:0] grant_id;
  logic [W-1:0] mul_a, mul_b;
  logic [2*W-1:0] mul_p;
  exp_t q[$];
  int total = 0;
  int fails = 0;
  int lat = 0;
  int runcnt = 0;
  int n;
  logic force_done = 1'b0;
  logic got_ack;
  mul_share_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in), .ack(ack),
    .result(result), .err(err), .busy(busy), .grant_id(grant_id), .mul_a(mul_a),
    .mul_b(mul_b), .mul_reset(mul_reset), .mul_done(mul_done), .mul_p(mul_p)
  );
  always #5 clk = ~clk;
  always @(posedge clk) runcnt <= mul_reset ? 0 : runcnt + 1;
  assign mul_done = force_done | (!mul_reset && lat != 0 && runcnt == lat - 1);
  assign mul_p = {16'h0, mul_a} * {16'h0, mul_b};
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] ev);
    total++;
    assert (obs === ev) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, ev);
    end
  endtask
  task automatic push(input logic [1:0] idx, input logic [31:0] res, input logic e);
    q.push_back('{idx: idx, res: res, err: e});
  endtask
  task automatic tick();
    exp_t e;
    @(negedge clk);
    got_ack = |ack;
    if (got_ack) begin
      if (q.size() == 0) chk("unexpected_ack", 64'(ack), 64'd0);
      else begin
        e = q.pop_front();
        chk("ack_idx", 64'(ack), 64'(1) << e.idx);
        chk("result", 64'(result), 64'(e.res));
        chk("err", 64'(err), 64'(e.err));
      end
    end
  endtask
  task automatic wait_ack(input int bound, output int cnt);
    cnt = 0;
    got_ack = 1'b0;
    while (!got_ack && cnt < bound) begin
      tick();
      cnt++;
    end
    if (!got_ack) chk("ack_timeout", 64'(cnt), 64'(bound + 1));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_ack", 64'(ack), 0);
    chk("rst_result", 64'(result), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_mul_reset", 64'(mul_reset), 1);
    chk("rst_grant", 64'(grant_id), 0);
    chk("rst_mul_a", 64'(mul_a), 0);
    // single request, done in the 4th RUN cycle
    lat = 4;
    a_in[15:0] = 16'd3;
    b_in[15:0] = 16'd5;
    req = 2'b01;
    push(2'd0, 32'd15, 1'b0);
    tick();
    chk("t1_busy", 64'(busy), 1);
    chk("t1_mul_reset", 64'(mul_reset), 0);
    chk("t1_grant", 64'(grant_id), 0);
    chk("t1_mul_a", 64'(mul_a), 3);
    chk("t1_mul_b", 64'(mul_b), 5);
    wait_ack(20, n);
    chk("t1_lat", 64'(n), 4);
    req = '0;
    tick();
    chk("t1_idle_busy", 64'(busy), 0);
    chk("t1_idle_mul_reset", 64'(mul_reset), 1);
    chk("t1_hold_result", 64'(result), 15);
    // both requesting continuously from ptr=0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    lat = 1;
    a_in = {16'h1234, 16'hFFFF};
    b_in = {16'h0010, 16'hFFFF};
    push(2'd0, 32'hFFFE0001, 1'b0);
    push(2'd1, 32'h00012340, 1'b0);
    push(2'd0, 32'hFFFE0001, 1'b0);
    push(2'd1, 32'h00012340, 1'b0);
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_ack(10, n);
      chk("t2_period", 64'(n), k == 0 ? 64'd2 : 64'd3);
    end
    req = '0;
    tick();
    // timeout, then a normal transaction
    lat = 0;
    a_in[31:16] = 16'd7;
    b_in[31:16] = 16'd9;
    req = 2'b10;
    push(2'd1, 32'd0, 1'b1);
    wait_ack(20, n);
    chk("t3_timeout_lat", 64'(n), TO + 1);
    req = '0;
    tick();
    lat = 2;
    a_in[15:0] = 16'd6;
    b_in[15:0] = 16'd7;
    req = 2'b01;
    push(2'd0, 32'd42, 1'b0);
    wait_ack(20, n);
    req = '0;
    tick();
    // done pulse in IDLE, then done on the last timeout cycle
    force_done = 1'b1;
    tick();
    chk("t4_idle_busy", 64'(busy), 0);
    chk("t4_idle_ack", 64'(ack), 0);
    tick();
    chk("t4_idle_busy2", 64'(busy), 0);
    chk("t4_idle_grant", 64'(grant_id), 0);
    force_done = 1'b0;
    lat = TO;
    a_in[31:16] = 16'd100;
    b_in[31:16] = 16'd200;
    req = 2'b10;
    push(2'd1, 32'd20000, 1'b0);
    wait_ack(20, n);
    chk("t4_final_lat", 64'(n), TO + 1);
    req = '0;
    tick();
    // reset while in RUN
    lat = 0;
    a_in[31:16] = 16'd3;
    b_in[31:16] = 16'd3;
    req = 2'b10;
    tick();
    chk("t5_busy", 64'(busy), 1);
    chk("t5_grant", 64'(grant_id), 1);
    tick();
    reset = 1'b1;
    req = '0;
    tick();
    chk("t5_rst_busy", 64'(busy), 0);
    chk("t5_rst_mul_reset", 64'(mul_reset), 1);
    chk("t5_rst_ack", 64'(ack), 0);
    chk("t5_rst_err", 64'(err), 0);
    chk("t5_rst_result", 64'(result), 0);
    chk("t5_rst_grant", 64'(grant_id), 0);
    chk("t5_rst_mul_a", 64'(mul_a), 0);
    reset = 1'b0;
    lat = 3;
    req = 2'b11;
    push(2'd0, 32'd42, 1'b0);
    tick();
    chk("t5_regrant", 64'(grant_id), 0);
    wait_ack(20, n);
    req = '0;
    tick();
    // requester drops req right after grant
    lat = 5;
    a_in[31:16] = 16'd11;
    b_in[31:16] = 16'd13;
    req = 2'b10;
    push(2'd1, 32'd143, 1'b0);
    tick();
    chk("t6_grant", 64'(grant_id), 1);
    req = '0;
    wait_ack(20, n);
    chk("t6_lat", 64'(n), 5);
    tick();
    chk("t6_idle", 64'(busy), 0);
    chk("queue_empty", 64'(q.size()), 0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/mul_share_arbiter.md
# mul_share_arbiter

Shares one multi-cycle multiplier between NREQ requesting controllers of the series-evaluation datapath, such as the two multiply stages of the term sequencer. It arbitrates requests round-robin, loads the operands, and drives the multiplier's active-low run/reset line. It waits for the multiplier's done flag and returns the product with a one-cycle acknowledge. A timeout counter guards against a multiplier that never finishes.

## Interface
Parameters:
- NREQ, 2, number of requesters (2..4)
- W, 16, operand width; product is 2W
- TIMEOUT, 64, max cycles in RUN before abort (≥2)

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- req  in  NREQ  per-requester request, level
- a_in  in  NREQ*W  operand A, requester i at [i*W +: W]
- b_in  in  NREQ*W  operand B, same packing
- ack  out  NREQ  one-cycle completion pulse to granted requester
- result  out  2W  product (or 0 on timeout), valid when any ack bit is high
- err  out  1  high with ack when the transaction timed out
- busy  out  1  high in any state but IDLE
- grant_id  out  2  index of current/last granted requester
- mul_a, mul_b  out  W  operands to shared multiplier
- mul_reset  out  1  multiplier hold: 1 = held in reset, 0 = run
- mul_done  in  1  multiplier finished; mul_p valid
- mul_p  in  2W  multiplier product

## Operation
- States: IDLE, RUN, RESP.
- IDLE:
  - mul_reset=1.
  - If any req bit is set, select the first set bit at or after pointer `ptr`, searching upward with wrap.
  - On the same edge: latch that requester's a/b into mul_a/mul_b, set grant_id, clear the timeout counter, go to RUN.
- RUN:
  - mul_reset=0; counter increments each cycle.
  - When mul_done=1: latch mul_p into result, err=0, go to RESP.
  - When counter reaches TIMEOUT-1 with mul_done=0: result=0, err=1, go to RESP.
  - mul_done and the timeout in the same cycle: done wins (err=0).
- RESP:
  - ack[grant_id]=1 for exactly this cycle; mul_reset=1.
  - ptr ← (grant_id+1) mod NREQ; go to IDLE.
- Requester contract:
  - Hold req and operands stable until ack.
  - Dropping req after grant does not abort; ack is still issued.
  - req of the granted requester still high in the IDLE cycle after RESP starts a new transaction, subject to round-robin.
- mul_done outside RUN is ignored.
- result and err hold their value until the next RESP.
- Reset, including mid-transaction:
  - Next state is IDLE; ptr=0, ack=0, err=0, result=0, grant_id=0, mul_a=mul_b=0.
  - mul_reset=1, busy=0.

## Timing
- The request in IDLE is sampled at edge 0. From cycle 1, state=RUN and mul_reset=0.
- When mul_done is first high in cycle k, RESP occurs in cycle k+1 with ack/result valid, and IDLE in cycle k+2.
- Minimum occupancy is 3 cycles, when mul_done arrives in the first RUN cycle. A new grant can be taken at the earliest in cycle k+2.
- Timeout: ack with err=1 occurs exactly TIMEOUT+1 cycles after the grant edge.
- All outputs are registered except mul_reset and busy, which decode from state.

## Structure
- Shared package/header: state encodings IDLE=2'd0, RUN=2'd1, RESP=2'd2; default widths.
- Sub-module rr_pick (combinational): inputs req and ptr; outputs any and idx. Priority search upward from ptr with wrap.
- Top holds the FSM, the timeout counter, the operand/result registers and ptr.

## Test plan
- Single request, NREQ=2, W=16: requester 0 with a=3, b=5, mul_done 4 cycles after grant. Required: ack[0] pulse, result=15, err=0, 6 cycles from req to IDLE.
- Both requesting continuously, ptr=0. Required: grants alternate 0,1,0,1; each ack goes only to the granted index; products correct for 0xFFFF×0xFFFF = 0xFFFE0001.
- mul_done held low, TIMEOUT=8. Required: ack with err=1 and result=0, 9 cycles after grant; next transaction returns err=0.
- mul_done pulses while IDLE and at the final timeout cycle. Required: IDLE pulse ignored (no grant, no ack); final-cycle done gives err=0 and the latched product.
- Reset asserted in RUN. Required: next cycle IDLE, mul_reset=1, no ack; the following request is granted to requester 0 (ptr=0).
- Requester drops req one cycle after grant. Required: transaction completes and ack still pulses for that requester.
